uart_tx_feeder: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_feeder_if.sv | 30 +++
 rtl/uart_sync_fifo.sv | 70 +++++++
 rtl/uart_tx_feeder.sv | 123 ++++++++++++
 tb/tb_uart_tx_feeder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type, transmit-feeder state encoding and
// default sizing constants for the feeder and its FIFO.
package uart_pkg;

    localparam int DEF_DEPTH         = 16;
    localparam int DEF_START_TIMEOUT = 32;
    localparam int DEF_GAP_CYCLES    = 0;

    typedef logic [7:0] uart_byte_t;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        WAIT_DONE,
        GAP
    } tx_feed_state_t;

    // Counter width large enough to hold the larger of two terminal counts.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Byte-write side and UART-core handshake of the transmit feeder.
// The master modport is the host/core side, the slave modport the feeder.
interface uart_tx_feeder_if
    import uart_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             wr_en_i;
    uart_byte_t       wr_data_i;
    logic             full_o;
    logic             empty_o;
    logic [LVL_W-1:0] level_o;
    logic             overflow_o;
    logic             txen_o;
    uart_byte_t       tx_data_o;
    logic             tx_ing_i;

    modport master (
        output wr_en_i, wr_data_i, tx_ing_i,
        input  full_o, empty_o, level_o, overflow_o, txen_o, tx_data_o
    );

    modport slave (
        input  wr_en_i, wr_data_i, tx_ing_i,
        output full_o, empty_o, level_o, overflow_o, txen_o, tx_data_o
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered level/full/empty and an overflow pulse.
// Shared between the UART transmit and receive paths.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [LW-1:0]    level_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_full;
    logic             r_empty;
    logic             r_overflow;

    logic             w_push;
    logic             w_pop;
    logic [LW-1:0]    w_level_nxt;

    // Flush dominates both directions; a push is judged against the pre-edge
    // full flag, so a same-cycle pop never makes room for it.
    assign w_push      = push_i && !r_full && !flush_i && !reset_i;
    assign w_pop       = pop_i && !r_empty && !flush_i;
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i || flush_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level    <= w_level_nxt;
            r_full     <= (w_level_nxt == LW'(DEPTH));
            r_empty    <= (w_level_nxt == '0);
            r_overflow <= push_i && r_full;
        end
    end

    assign rd_data_o  = r_mem[r_rd_ptr];
    assign level_o    = r_level;
    assign full_o     = r_full;
    assign empty_o    = r_empty;
    assign overflow_o = r_overflow;

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues host bytes and launches them one at a time into the UART core,
// with an optional post-frame idle gap and a start-of-frame watchdog.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH         = DEF_DEPTH,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic               flush_i,
    uart_tx_feeder_if.slave    tx_bus,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam int CW       = cnt_width(START_TIMEOUT, GAP_CYCLES);
    localparam int TO_LAST  = (START_TIMEOUT > 1) ? START_TIMEOUT - 1 : 0;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    tx_feed_state_t r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_txen;
    uart_byte_t     r_tx_data;
    logic           r_busy;
    logic           r_timeout;

    uart_byte_t     w_head;
    logic           w_empty;
    logic           w_pop;

    assign w_pop = (r_state == LAUNCH);

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .flush_i    (flush_i),
        .push_i     (tx_bus.wr_en_i),
        .pop_i      (w_pop),
        .wr_data_i  (tx_bus.wr_data_i),
        .rd_data_o  (w_head),
        .level_o    (tx_bus.level_o),
        .full_o     (tx_bus.full_o),
        .empty_o    (w_empty),
        .overflow_o (tx_bus.overflow_o)
    );

    // r_cnt counts cycles since the launch strobe, the LAUNCH cycle included,
    // so the watchdog fires START_TIMEOUT cycles after txen.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_txen    <= 1'b0;
            r_tx_data <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_txen    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable_i && !w_empty && !flush_i) begin
                        r_state   <= LAUNCH;
                        r_txen    <= 1'b1;
                        r_tx_data <= w_head;
                        r_busy    <= 1'b1;
                    end
                end
                LAUNCH: begin
                    r_state <= WAIT_START;
                    r_cnt   <= CW'(1);
                end
                WAIT_START: begin
                    if (tx_bus.tx_ing_i) begin
                        r_state <= WAIT_DONE;
                    end else if (r_cnt >= CW'(TO_LAST)) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_bus.tx_ing_i) begin
                        if (GAP_CYCLES > 0) begin
                            r_state <= GAP;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (r_cnt >= CW'(GAP_LAST)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_bus.empty_o   = w_empty;
    assign tx_bus.txen_o    = r_txen;
    assign tx_bus.tx_data_o = r_tx_data;
    assign busy_o           = r_busy;
    assign timeout_o        = r_timeout;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench: one default feeder (GAP_CYCLES=0) and one with GAP_CYCLES=5,
// each driven by a small UART-core model on tx_ing_i.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic en0, fl0, busy0, to0;
    logic eng, flg, busyg, tog;
    int   cyc = 0;
    int   vec = 0;
    int   errs = 0;

    int   resp0 = 1, frame0 = 100;
    int   respg = 1, frameg = 10;

    logic [7:0] tx0_q[$], txg_q[$];
    int         tx0_t[$], txg_t[$], to0_tq[$], fallg_q[$];
    int         ovf0 = 0, fall0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_feeder_if #(.DEPTH(16)) f0();
    uart_tx_feeder_if #(.DEPTH(16)) fg();

    uart_tx_feeder #(.DEPTH(16), .START_TIMEOUT(32), .GAP_CYCLES(0)) dut0 (
        .clock_i(clk), .reset_i(rst), .enable_i(en0), .flush_i(fl0),
        .tx_bus(f0), .busy_o(busy0), .timeout_o(to0)
    );

    uart_tx_feeder #(.DEPTH(16), .START_TIMEOUT(32), .GAP_CYCLES(5)) dutg (
        .clock_i(clk), .reset_i(rst), .enable_i(eng), .flush_i(flg),
        .tx_bus(fg), .busy_o(busyg), .timeout_o(tog)
    );

    // Core models: raise tx_ing 2 cycles after txen, hold it for a frame.
    initial begin
        f0.tx_ing_i = 1'b0;
        forever begin
            @(negedge clk);
            if (f0.txen_o && resp0 != 0) begin
                repeat (2) @(posedge clk);
                #1 f0.tx_ing_i = 1'b1;
                repeat (frame0) @(posedge clk);
                #1 f0.tx_ing_i = 1'b0;
                fall0 = cyc;
            end
        end
    end

    initial begin
        fg.tx_ing_i = 1'b0;
        forever begin
            @(negedge clk);
            if (fg.txen_o && respg != 0) begin
                repeat (2) @(posedge clk);
                #1 fg.tx_ing_i = 1'b1;
                repeat (frameg) @(posedge clk);
                #1 fg.tx_ing_i = 1'b0;
                fallg_q.push_back(cyc);
            end
        end
    end

    // Event log; a stamp is the number of rising edges seen so far.
    always @(negedge clk) begin
        if (f0.txen_o) begin tx0_q.push_back(f0.tx_data_o); tx0_t.push_back(cyc); end
        if (fg.txen_o) begin txg_q.push_back(fg.tx_data_o); txg_t.push_back(cyc); end
        if (f0.overflow_o) ovf0++;
        if (to0) to0_tq.push_back(cyc);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        tx0_q.delete(); tx0_t.delete(); txg_q.delete(); txg_t.delete();
        to0_tq.delete(); fallg_q.delete(); ovf0 = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        vec++; if (f0.full_o !== 1'b0) begin errs++; $display("FAIL rst_full got %b want 0", f0.full_o); end
        vec++; if (f0.empty_o !== 1'b1) begin errs++; $display("FAIL rst_empty got %b want 1", f0.empty_o); end
        vec++; if (f0.level_o !== 5'd0) begin errs++; $display("FAIL rst_level got %0d want 0", f0.level_o); end
        vec++; if (f0.overflow_o !== 1'b0) begin errs++; $display("FAIL rst_ovf got %b want 0", f0.overflow_o); end
        vec++; if (f0.txen_o !== 1'b0) begin errs++; $display("FAIL rst_txen got %b want 0", f0.txen_o); end
        vec++; if (f0.tx_data_o !== 8'h00) begin errs++; $display("FAIL rst_data got %h want 00", f0.tx_data_o); end
        vec++; if (busy0 !== 1'b0 || to0 !== 1'b0) begin errs++; $display("FAIL rst_busy_to got %b%b want 00", busy0, to0); end
        vec++; if (busyg !== 1'b0 || fg.empty_o !== 1'b1) begin errs++; $display("FAIL rst_gapdut got busy %b empty %b want 0 1", busyg, fg.empty_o); end
    endtask

    task automatic test_single();
        int n;
        clear_logs();
        resp0 = 1; frame0 = 100; en0 = 1'b1;
        f0.wr_en_i = 1'b1; f0.wr_data_i = 8'hA5;
        tick();                                   // edge N
        f0.wr_en_i = 1'b0;
        vec++; if (f0.level_o !== 5'd1 || f0.empty_o !== 1'b0) begin errs++; $display("FAIL single_push got lvl %0d empty %b want 1 0", f0.level_o, f0.empty_o); end
        vec++; if (f0.txen_o !== 1'b0) begin errs++; $display("FAIL single_early_txen got %b want 0", f0.txen_o); end
        tick();                                   // edge N+1
        vec++; if (f0.txen_o !== 1'b1 || f0.tx_data_o !== 8'hA5) begin errs++; $display("FAIL single_launch got txen %b data %h want 1 a5", f0.txen_o, f0.tx_data_o); end
        tick();
        vec++; if (f0.txen_o !== 1'b0 || busy0 !== 1'b1) begin errs++; $display("FAIL single_strobe got txen %b busy %b want 0 1", f0.txen_o, busy0); end
        n = 0;
        while (busy0 && n < 300) begin tick(); n++; end
        vec++; if (n >= 300) begin errs++; $display("FAIL single_done_wait got busy %b want 0", busy0); end
        vec++; if (f0.tx_ing_i !== 1'b0 || cyc !== fall0 + 1) begin errs++; $display("FAIL single_idle got tx_ing %b cyc %0d want 0 %0d", f0.tx_ing_i, cyc, fall0 + 1); end
        vec++; if (f0.tx_data_o !== 8'hA5 || tx0_q.size() !== 1) begin errs++; $display("FAIL single_hold got data %h launches %0d want a5 1", f0.tx_data_o, tx0_q.size()); end
    endtask

    task automatic test_overflow_order();
        int n;
        clear_logs();
        en0 = 1'b0; frame0 = 4;
        for (int i = 0; i < 17; i++) begin
            f0.wr_en_i = 1'b1; f0.wr_data_i = 8'(i);
            tick();
            if (i == 0) begin
                vec++; if (f0.level_o !== 5'd1 || f0.full_o !== 1'b0) begin errs++; $display("FAIL ovf_first got lvl %0d full %b want 1 0", f0.level_o, f0.full_o); end
            end
            if (i == 15) begin
                vec++; if (f0.full_o !== 1'b1 || f0.level_o !== 5'd16 || f0.overflow_o !== 1'b0) begin errs++; $display("FAIL ovf_full got full %b lvl %0d ovf %b want 1 16 0", f0.full_o, f0.level_o, f0.overflow_o); end
            end
            if (i == 16) begin
                vec++; if (f0.overflow_o !== 1'b1 || f0.level_o !== 5'd16) begin errs++; $display("FAIL ovf_pulse got ovf %b lvl %0d want 1 16", f0.overflow_o, f0.level_o); end
            end
        end
        f0.wr_en_i = 1'b0;
        tick();
        vec++; if (f0.overflow_o !== 1'b0 || tx0_q.size() !== 0) begin errs++; $display("FAIL ovf_clear got ovf %b launches %0d want 0 0", f0.overflow_o, tx0_q.size()); end
        en0 = 1'b1;
        tick();
        n = 0;
        while ((busy0 || !f0.empty_o) && n < 2000) begin tick(); n++; end
        vec++; if (n >= 2000 || tx0_q.size() !== 16) begin errs++; $display("FAIL drain got launches %0d want 16", tx0_q.size()); end
        for (int i = 0; i < 16 && i < tx0_q.size(); i++) begin
            vec++; if (tx0_q[i] !== 8'(i)) begin errs++; $display("FAIL order[%0d] got %h want %h", i, tx0_q[i], 8'(i)); end
        end
    endtask

    task automatic test_timeout();
        int n;
        clear_logs();
        resp0 = 0; en0 = 1'b1;
        f0.wr_en_i = 1'b1; f0.wr_data_i = 8'h11; tick();
        f0.wr_data_i = 8'h22; tick();
        f0.wr_en_i = 1'b0;
        n = 0;
        while (to0_tq.size() < 2 && n < 200) begin tick(); n++; end
        vec++; if (n >= 200 || tx0_q.size() !== 2) begin errs++; $display("FAIL to_wait got timeouts %0d launches %0d want 2 2", to0_tq.size(), tx0_q.size()); end
        if (tx0_q.size() == 2 && to0_tq.size() == 2) begin
            vec++; if (tx0_q[0] !== 8'h11 || tx0_q[1] !== 8'h22) begin errs++; $display("FAIL to_data got %h %h want 11 22", tx0_q[0], tx0_q[1]); end
            vec++; if (to0_tq[0] !== tx0_t[0] + 32) begin errs++; $display("FAIL to_delay got %0d want %0d", to0_tq[0], tx0_t[0] + 32); end
            vec++; if (tx0_t[1] !== to0_tq[0] + 1) begin errs++; $display("FAIL to_relaunch got %0d want %0d", tx0_t[1], to0_tq[0] + 1); end
            vec++; if (to0_tq[1] !== tx0_t[1] + 32) begin errs++; $display("FAIL to_delay2 got %0d want %0d", to0_tq[1], tx0_t[1] + 32); end
        end
        tick(2);
        vec++; if (busy0 !== 1'b0 || f0.tx_data_o !== 8'h22) begin errs++; $display("FAIL to_after got busy %b data %h want 0 22", busy0, f0.tx_data_o); end
        resp0 = 1;
    endtask

    task automatic test_gap();
        int n;
        clear_logs();
        eng = 1'b0; respg = 1; frameg = 10;
        fg.wr_en_i = 1'b1; fg.wr_data_i = 8'h3C; tick();
        fg.wr_data_i = 8'hC3; tick();
        fg.wr_en_i = 1'b0;
        eng = 1'b1;
        n = 0;
        while (txg_q.size() < 2 && n < 200) begin tick(); n++; end
        vec++; if (n >= 200 || fallg_q.size() < 1) begin errs++; $display("FAIL gap_wait got launches %0d falls %0d want 2 1", txg_q.size(), fallg_q.size()); end
        if (txg_q.size() == 2 && fallg_q.size() >= 1) begin
            vec++; if (txg_q[0] !== 8'h3C || txg_q[1] !== 8'hC3) begin errs++; $display("FAIL gap_data got %h %h want 3c c3", txg_q[0], txg_q[1]); end
            vec++; if (txg_t[1] !== fallg_q[0] + 7) begin errs++; $display("FAIL gap_spacing got %0d want %0d", txg_t[1], fallg_q[0] + 7); end
        end
        n = 0;
        while (busyg && n < 200) begin tick(); n++; end
        vec++; if (n >= 200) begin errs++; $display("FAIL gap_done got busy %b want 0", busyg); end
    endtask

    task automatic test_flush();
        int n;
        clear_logs();
        en0 = 1'b0; resp0 = 1; frame0 = 20;
        for (int i = 0; i < 5; i++) begin
            f0.wr_en_i = 1'b1; f0.wr_data_i = 8'h50 + 8'(i); tick();
        end
        f0.wr_en_i = 1'b0;
        en0 = 1'b1;
        n = 0;
        while (f0.tx_ing_i !== 1'b1 && n < 50) begin tick(); n++; end
        vec++; if (n >= 50) begin errs++; $display("FAIL flush_start got tx_ing %b want 1", f0.tx_ing_i); end
        tick(2);
        vec++; if (f0.level_o !== 5'd4) begin errs++; $display("FAIL flush_pre_lvl got %0d want 4", f0.level_o); end
        fl0 = 1'b1; f0.wr_en_i = 1'b1; f0.wr_data_i = 8'hEE;
        tick();
        fl0 = 1'b0; f0.wr_en_i = 1'b0;
        vec++; if (f0.level_o !== 5'd0 || f0.empty_o !== 1'b1 || f0.full_o !== 1'b0) begin errs++; $display("FAIL flush_clear got lvl %0d empty %b full %b want 0 1 0", f0.level_o, f0.empty_o, f0.full_o); end
        vec++; if (busy0 !== 1'b1 || f0.overflow_o !== 1'b0) begin errs++; $display("FAIL flush_inflight got busy %b ovf %b want 1 0", busy0, f0.overflow_o); end
        n = 0;
        while (busy0 && n < 100) begin tick(); n++; end
        tick(20);
        vec++; if (n >= 100 || tx0_q.size() !== 1 || ovf0 !== 0) begin errs++; $display("FAIL flush_after got launches %0d ovf %0d want 1 0", tx0_q.size(), ovf0); end
        vec++; if (tx0_q.size() > 0 && tx0_q[0] !== 8'h50) begin errs++; $display("FAIL flush_byte got %h want 50", tx0_q[0]); end
    endtask

    task automatic test_reset_mid();
        int n, to_before;
        clear_logs();
        resp0 = 0; en0 = 1'b1;
        f0.wr_en_i = 1'b1; f0.wr_data_i = 8'h77; tick();
        f0.wr_data_i = 8'h78; tick();
        f0.wr_en_i = 1'b0;
        n = 0;
        while (tx0_q.size() < 1 && n < 20) begin tick(); n++; end
        tick(3);
        vec++; if (busy0 !== 1'b1 || f0.txen_o !== 1'b0) begin errs++; $display("FAIL rmid_pre got busy %b txen %b want 1 0", busy0, f0.txen_o); end
        to_before = to0_tq.size();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vec++; if (busy0 !== 1'b0 || to0 !== 1'b0 || f0.txen_o !== 1'b0 || f0.tx_data_o !== 8'h00) begin errs++; $display("FAIL rmid_outs got busy %b to %b txen %b data %h want 0 0 0 00", busy0, to0, f0.txen_o, f0.tx_data_o); end
        vec++; if (f0.level_o !== 5'd0 || f0.empty_o !== 1'b1 || f0.full_o !== 1'b0 || f0.overflow_o !== 1'b0) begin errs++; $display("FAIL rmid_fifo got lvl %0d empty %b full %b ovf %b want 0 1 0 0", f0.level_o, f0.empty_o, f0.full_o, f0.overflow_o); end
        tick(60);
        vec++; if (tx0_q.size() !== 1 || to0_tq.size() !== to_before) begin errs++; $display("FAIL rmid_quiet got launches %0d timeouts %0d want 1 %0d", tx0_q.size(), to0_tq.size(), to_before); end
        resp0 = 1; frame0 = 10;
        f0.wr_en_i = 1'b1; f0.wr_data_i = 8'h79; tick();
        f0.wr_en_i = 1'b0;
        n = 0;
        while (tx0_q.size() < 2 && n < 20) begin tick(); n++; end
        vec++; if (tx0_q.size() !== 2 || tx0_q[tx0_q.size()-1] !== 8'h79) begin errs++; $display("FAIL rmid_new got launches %0d last %h want 2 79", tx0_q.size(), tx0_q[tx0_q.size()-1]); end
        n = 0;
        while (busy0 && n < 200) begin tick(); n++; end
        vec++; if (n >= 200) begin errs++; $display("FAIL rmid_done got busy %b want 0", busy0); end
    endtask

    initial begin
        rst = 1'b1; en0 = 1'b0; fl0 = 1'b0; eng = 1'b0; flg = 1'b0;
        f0.wr_en_i = 1'b0; f0.wr_data_i = '0;
        fg.wr_en_i = 1'b0; fg.wr_data_i = '0;
        test_reset();
        test_single();
        test_overflow_order();
        test_timeout();
        test_gap();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
